// File: rtl/fifo_wr_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_ctrl
//
// Purpose:
//   Controller for a single-clock FIFO memory. It owns the write and read
//   pointers, derives full/empty status, and shares the memory's single write
//   port between two requesters using round-robin arbitration. All memory
//   address, write-enable and write-data traffic is produced here, and
//   consumers pop through the read side.
//
// Handshake semantics (applies to every request/grant and pop in this block):
//   A requester holds reqN high with valid wdataN. In any cycle where gntN is
//   high, the word is written to memory at the next rising CLK edge. A request
//   seen while gntN is low is not consumed. A pop is accepted in any cycle with
//   rd_en && !empty. rd_data is valid in that same cycle and the read pointer
//   advances at the edge.
//
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   req0/req1         write requests
//   wdata0/wdata1     write data per requester
//   gnt0/gnt1         combinational grants
//   rd_en             pop request
//   rd_data           head word (mem_rdata passthrough)
//   empty/full        registered-pointer status
//   drop_err          sticky: a request arrived while full
//   mem_winc          memory write enable
//   mem_wfull         copy of full for the memory
//   mem_waddr         memory write address
//   mem_wdata         memory write data
//   mem_raddr         memory read address
//   mem_rdata         memory combinational read data
//   almost_full       occupancy >= AF_LEVEL. This output exists only when
//                     FIFO_CTRL_ALMOST_FULL_EN is defined.
//
// Configuration macro: FIFO_CTRL_ALMOST_FULL_EN
// -----------------------------------------------------------------------------
module fifo_wr_arbiter_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADRRSIZE   = 3,
    parameter int AF_LEVEL   = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  drop_err,
    output logic                  mem_winc,
    output logic                  mem_wfull,
    output logic [ADRRSIZE-1:0]   mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADRRSIZE-1:0]   mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef FIFO_CTRL_ALMOST_FULL_EN
    ,
    output logic                  almost_full
`endif
);

    // Pointer width carries one extra wrap bit above the address bits.
    localparam int PW = ADRRSIZE + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_next;
    logic [PW-1:0] rptr_next;
    logic          last_gnt;   // 0: requester 0 won last, 1: requester 1 won last
    logic          last_gnt_next;
    logic          wr_go;
    logic          rd_go;
    logic          any_req;

    // -------------------------------------------------------------------------
    // Status from registered pointers only. These do not depend on req or rd_en.
    // -------------------------------------------------------------------------
    assign empty     = (wptr == rptr);
    assign full      = (wptr[PW-1] != rptr[PW-1]) &&
                       (wptr[ADRRSIZE-1:0] == rptr[ADRRSIZE-1:0]);
    assign mem_wfull = full;

    assign mem_waddr = wptr[ADRRSIZE-1:0];
    assign mem_raddr = rptr[ADRRSIZE-1:0];
    assign rd_data   = mem_rdata;

    // -------------------------------------------------------------------------
    // Round-robin arbitration. On a tie, the requester that did not win last
    // time is granted. Grants are masked while full and while in reset, so a
    // reset cycle never writes to memory.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST && !full) begin
            if (req0 && req1) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign wr_go     = gnt0 | gnt1;
    assign mem_winc  = wr_go;
    assign mem_wdata = gnt0 ? wdata0 : wdata1;

    // A pop on an empty FIFO is ignored. Because empty comes from registered
    // pointers, a write and a pop on an empty FIFO in the same cycle accept
    // only the write.
    assign rd_go   = !RST && rd_en && !empty;
    assign any_req = req0 | req1;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wptr_next     = wptr;
        rptr_next     = rptr;
        last_gnt_next = last_gnt;
        if (wr_go) begin
            wptr_next     = wptr + PTR_ONE;
            last_gnt_next = gnt1;
        end
        if (rd_go) begin
            rptr_next = rptr + PTR_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr     <= '0;
            rptr     <= '0;
            last_gnt <= 1'b1;   // requester 0 wins the first tie
            drop_err <= 1'b0;
        end else begin
            wptr     <= wptr_next;
            rptr     <= rptr_next;
            last_gnt <= last_gnt_next;
            if (any_req && full) begin
                drop_err <= 1'b1;
            end
        end
    end

`ifdef FIFO_CTRL_ALMOST_FULL_EN
    // -------------------------------------------------------------------------
    // Almost-full is registered from post-update occupancy, so it moves on the
    // same edge as full. The modulo difference of the wrap-bit pointers gives
    // the occupancy, which is 0..2^ADRRSIZE.
    // -------------------------------------------------------------------------
    localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
    logic [PW-1:0] occ_next;

    assign occ_next = wptr_next - rptr_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (occ_next >= AF_THR);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter_ctrl
//
// Directed bench for fifo_wr_arbiter_ctrl with a behavioural 8x8 memory that
// has a synchronous write and a combinational read. Inputs change 1 time unit
// after each rising edge. Outputs are checked a further time unit later, so
// they are sampled well away from the active edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req0, req1, rd_en;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic [DW-1:0] rd_data;
    logic          empty, full, drop_err;
    logic          mem_winc, mem_wfull;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef FIFO_CTRL_ALMOST_FULL_EN
    logic          almost_full;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    end
    always @(posedge CLK) begin
        if (mem_winc) mem[mem_waddr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_raddr];

    // ---------------- DUT ----------------
    fifo_wr_arbiter_ctrl #(.DATA_WIDTH(DW), .ADRRSIZE(AW), .AF_LEVEL(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req0       (req0),
        .req1       (req1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .drop_err   (drop_err),
        .mem_winc   (mem_winc),
        .mem_wfull  (mem_wfull),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata)
`ifdef FIFO_CTRL_ALMOST_FULL_EN
        ,
        .almost_full(almost_full)
`endif
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then leave a gap before inputs change.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        req0 = 1'b0; req1 = 1'b0; rd_en = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        RST = 1'b1; req0 = 1'b1; req1 = 1'b1; rd_en = 1'b1;
        wdata0 = 8'h00; wdata1 = 8'h00;
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_winc", mem_winc, 0);
        tick();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_drop", drop_err, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_raddr", mem_raddr, 0);
`ifdef FIFO_CTRL_ALMOST_FULL_EN
        check("rst_af", almost_full, 0);
`endif
        RST = 1'b0; idle();

        // ---- fill with requester 0 only: A0..A7 ----
        for (int i = 0; i < 8; i++) begin
            req0 = 1'b1; wdata0 = 8'hA0 + 8'(i);
            #1;
            check("fill_gnt0", gnt0, 1);
            check("fill_gnt1", gnt1, 0);
            check("fill_waddr", mem_waddr, i);
            check("fill_wdata", mem_wdata, 8'hA0 + i);
            tick();
            check("fill_empty", empty, 0);
            check("fill_full", full, (i == 7) ? 1 : 0);
            check("fill_wfull", mem_wfull, (i == 7) ? 1 : 0);
`ifdef FIFO_CTRL_ALMOST_FULL_EN
            check("fill_af", almost_full, (i >= 5) ? 1 : 0);
`endif
        end
        idle();

        // ---- full: req1 refused, pop proceeds ----
        req1 = 1'b1; wdata1 = 8'hEE; rd_en = 1'b1;
        #1;
        check("full_gnt1", gnt1, 0);
        check("full_gnt0", gnt0, 0);
        check("full_winc", mem_winc, 0);
        check("full_rdata", rd_data, 8'hA0);
        tick();
        idle();
        #1;
        check("full_drop", drop_err, 1);
        check("full_clear", full, 0);

        // ---- drain A1..A7, drop_err stays set ----
        for (int k = 1; k < 8; k++) begin
            rd_en = 1'b1;
            #1;
            check("drain_rdata", rd_data, 8'hA0 + k);
            tick();
            check("drain_empty", empty, (k == 7) ? 1 : 0);
            check("drain_full", full, 0);
`ifdef FIFO_CTRL_ALMOST_FULL_EN
            check("drain_af", almost_full, (k == 1) ? 1 : 0);
`endif
        end
        idle();
        check("drain_drop_sticky", drop_err, 1);

        // ---- reset mid-stream with a request and pop pending ----
        req0 = 1'b1; wdata0 = 8'h33;
        tick();
        tick();
        check("pre_rst_empty", empty, 0);
        RST = 1'b1; req0 = 1'b1; rd_en = 1'b1;
        #1;
        check("midrst_gnt0", gnt0, 0);
        check("midrst_winc", mem_winc, 0);
        tick();
        RST = 1'b0; idle();
        #1;
        check("midrst_empty", empty, 1);
        check("midrst_full", full, 0);
        check("midrst_drop", drop_err, 0);
        check("midrst_waddr", mem_waddr, 0);
        check("midrst_raddr", mem_raddr, 0);
`ifdef FIFO_CTRL_ALMOST_FULL_EN
        check("midrst_af", almost_full, 0);
`endif

        // ---- tie from reset: grant order 0,1,0,1 ----
        req0 = 1'b1; req1 = 1'b1; wdata0 = 8'h11; wdata1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("tie_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
            check("tie_gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
            check("tie_wdata", mem_wdata, (i % 2 == 0) ? 8'h11 : 8'h22);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            #1;
            check("tie_rdata", rd_data, (i % 2 == 0) ? 8'h11 : 8'h22);
            tick();
        end
        idle();
        check("tie_empty", empty, 1);

        // ---- empty: write 5C with pop in same cycle ----
        req0 = 1'b1; wdata0 = 8'h5C; rd_en = 1'b1;
        #1;
        check("ewp_gnt0", gnt0, 1);
        check("ewp_raddr_before", mem_raddr, 4);
        tick();
        req0 = 1'b0; rd_en = 1'b1;
        #1;
        check("ewp_raddr_after", mem_raddr, 4);
        check("ewp_empty", empty, 0);
        check("ewp_rdata", rd_data, 8'h5C);
        tick();
        idle();
        check("ewp_pop_empty", empty, 1);
        check("ewp_pop_raddr", mem_raddr, 5);

        // ---- stream 20 words via requester 1, across pointer wrap ----
        for (int i = 0; i <= 20; i++) begin
            req1  = (i < 20);
            wdata1 = 8'hB0 + 8'(i);
            rd_en = (i > 0);
            #1;
            if (i < 20) check("strm_gnt1", gnt1, 1);
            if (i > 0)  check("strm_rdata", rd_data, 8'hB0 + i - 1);
            tick();
            check("strm_full", full, 0);
            check("strm_empty", empty, (i == 20) ? 1 : 0);
        end
        idle();
        check("strm_waddr", mem_waddr, 1);
        check("strm_raddr", mem_raddr, 1);
        check("strm_drop", drop_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
